counter_job_arbiter: RTL and testbench

Two-requester scheduler that shares one up/down counter (CLK/RST/MODE/OUT style, 4-bit) between clients. Each requester submits a count job: a direction and a step count. The block arbitrates round-robin, acknowledges the winner, then drives the counter's enable and MODE for exactly that many clock cycles. It pulses DONE tagged with the requester ID. It sits between the client logic and the counter's MODE/enable pins; the counter's own RST stays under system control.

---
 rtl/counter_job_arbiter.sv | 96 +++++++++
 tb/tb_counter_job_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_job_arbiter.sv
// Round-robin scheduler that lends one shared up/down counter to two requesters,
// driving its enable/MODE for exactly the requested number of cycles per job.
module counter_job_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [1:0]         REQ,
    input  logic [1:0]         REQ_MODE,
    input  logic [2*WIDTH-1:0] REQ_STEPS,
    output logic [1:0]         ACK,
    output logic               CNT_EN,
    output logic               CNT_MODE,
    output logic               BUSY,
    output logic               DONE,
    output logic               DONE_ID
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RUN,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               win_q, win_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   steps_q, steps_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               pick;

    // Direction register resets to "up" so the counter MODE pin sees 1 out of reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            mode_q  <= 1'b1;
            steps_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            mode_q  <= mode_d;
            steps_q <= steps_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        mode_d  = mode_q;
        steps_d = steps_q;
        rem_d   = rem_q;
        pick    = (REQ == 2'b11) ? ptr_q : REQ[1];
        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    win_d   = pick;
                    mode_d  = REQ_MODE[pick];
                    steps_d = REQ_STEPS[(pick ? WIDTH : 0) +: WIDTH];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                rem_d   = steps_q;
                state_d = (steps_q != '0) ? S_RUN : S_FIN;
            end
            S_RUN: begin
                rem_d = rem_q - WIDTH'(1);
                if (rem_q == WIDTH'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                ptr_d   = ~win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All outputs decode from registered state only; REQ never reaches them combinationally.
    assign ACK      = (state_q == S_GRANT) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign CNT_EN   = (state_q == S_RUN);
    assign CNT_MODE = mode_q;
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = (state_q == S_FIN);
    assign DONE_ID  = (state_q == S_FIN) && win_q;

endmodule

// File: tb/tb_counter_job_arbiter.sv
// Directed + randomized bench: a job-level timing model predicts every output cycle,
// and a bench-side 4-bit counter checks the net effect on the shared counter.
module tb_counter_job_arbiter;

    localparam int WIDTH = 4;

    typedef struct {
        bit mode;
        int steps;
    } job_t;

    logic               CLK;
    logic               RST;
    logic [1:0]         REQ;
    logic [1:0]         REQ_MODE;
    logic [2*WIDTH-1:0] REQ_STEPS;
    logic [1:0]         ACK;
    logic               CNT_EN;
    logic               CNT_MODE;
    logic               BUSY;
    logic               DONE;
    logic               DONE_ID;

    counter_job_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_MODE(REQ_MODE), .REQ_STEPS(REQ_STEPS),
        .ACK(ACK), .CNT_EN(CNT_EN), .CNT_MODE(CNT_MODE), .BUSY(BUSY),
        .DONE(DONE), .DONE_ID(DONE_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // The shared counter the block is steering.
    logic [3:0] cnt;
    logic       cnt_ld;
    logic [3:0] cnt_val;
    always @(posedge CLK) begin
        if (cnt_ld) cnt <= cnt_val;
        else if (CNT_EN) cnt <= CNT_MODE ? cnt + 4'd1 : cnt - 4'd1;
    end

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int dut_dones = 0;

    job_t q0[$];
    job_t q1[$];

    // Job-level model: one job in flight, described by the cycles its events fall in.
    int m_ack, m_en0, m_en1, m_done, m_idle;
    int m_win, m_ptr, m_mode, m_prev_mode, m_out, m_start, m_steps;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive_req();
        REQ[0]       = (q0.size() != 0);
        REQ[1]       = (q1.size() != 0);
        REQ_MODE[0]  = (q0.size() != 0) ? q0[0].mode : 1'b0;
        REQ_MODE[1]  = (q1.size() != 0) ? q1[0].mode : 1'b0;
        REQ_STEPS[3:0] = (q0.size() != 0) ? 4'(q0[0].steps) : 4'd0;
        REQ_STEPS[7:4] = (q1.size() != 0) ? 4'(q1[0].steps) : 4'd0;
    endtask

    task automatic model_reset();
        m_ack = -100; m_en0 = 0; m_en1 = -1; m_done = -100; m_idle = cyc;
        m_ptr = 0; m_win = 0; m_mode = 1; m_prev_mode = 1;
        q0.delete(); q1.delete();
        drive_req();
    endtask

    task automatic check_outputs();
        logic [1:0] e_ack;
        e_ack = (cyc == m_ack) ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
        if (DONE === 1'b1) dut_dones++;
        check("ACK", 32'(ACK), 32'(e_ack));
        check("CNT_EN", 32'(CNT_EN), 32'(cyc >= m_en0 && cyc <= m_en1));
        check("CNT_MODE", 32'(CNT_MODE), 32'((cyc >= m_ack) ? m_mode : m_prev_mode));
        check("BUSY", 32'(BUSY), 32'(cyc < m_idle));
        check("DONE", 32'(DONE), 32'(cyc == m_done));
        if (cyc == m_done) begin
            check("DONE_ID", 32'(DONE_ID), 32'(m_win));
            check("OUT_at_done", 32'(cnt), 32'(m_out));
        end
        if (RST) check("DONE_ID_rst", 32'(DONE_ID), 32'd0);
    endtask

    task automatic capture();
        job_t j;
        bit r0, r1;
        int w;
        r0 = (q0.size() != 0);
        r1 = (q1.size() != 0);
        w = (r0 && r1) ? m_ptr : (r1 ? 1 : 0);
        j = (w == 1) ? q1[0] : q0[0];
        m_win = w;
        m_prev_mode = m_mode;
        m_mode = j.mode;
        m_steps = j.steps;
        m_ack = cyc + 1;
        m_en0 = cyc + 2;
        m_en1 = cyc + 1 + j.steps;
        m_done = cyc + 2 + j.steps;
        m_idle = cyc + 3 + j.steps;
        m_ptr = 1 - w;
        m_start = m_out;
        m_out = j.mode ? (m_out + j.steps) & 15 : (m_out - j.steps) & 15;
    endtask

    // One clock: check this cycle's outputs, act as the requesters, then let the model decide.
    task automatic step();
        @(negedge CLK);
        cyc++;
        check_outputs();
        if (cyc == m_ack) begin
            if (m_win == 1) void'(q1.pop_front());
            else void'(q0.pop_front());
        end
        drive_req();
        cnt_ld = 1'b0;
        if (!RST && cyc >= m_idle && (q0.size() != 0 || q1.size() != 0)) capture();
    endtask

    task automatic load_cnt(input int v);
        cnt_val = 4'(v);
        cnt_ld = 1'b1;
        m_out = v & 15;
    endtask

    task automatic push(input int who, input bit mode, input int steps);
        job_t j;
        j.mode = mode;
        j.steps = steps;
        if (who == 1) q1.push_back(j);
        else q0.push_back(j);
        drive_req();
        if (!RST && cyc >= m_idle) capture();
    endtask

    task automatic run_quiet(input int max_cyc);
        int b;
        b = 0;
        while ((q0.size() != 0 || q1.size() != 0 || cyc < m_idle) && b < max_cyc) begin
            step();
            b++;
        end
        check("quiet_within_bound", 32'(b < max_cyc), 32'd1);
        step();
    endtask

    task automatic pulse_reset();
        int done_enables;
        RST = 1'b1;
        #1;
        if (cyc >= m_en0 && cyc <= m_idle) begin
            done_enables = (cyc - m_en0 > m_steps) ? m_steps : cyc - m_en0;
            m_out = m_mode ? (m_start + done_enables) & 15 : (m_start - done_enables) & 15;
        end
        model_reset();
        check_outputs();
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        int d0;
        RST = 1'b1;
        cnt_ld = 1'b0;
        cnt_val = 4'd0;
        model_reset();
        #1;
        check_outputs();
        load_cnt(0);
        step();
        step();
        RST = 1'b0;
        step();

        // Single job: requester 0, up, 5 steps.
        push(0, 1'b1, 5);
        run_quiet(100);
        check("single_out", 32'(cnt), 32'd5);

        // Simultaneous requests from a fresh reset (PTR=0).
        pulse_reset();
        load_cnt(0);
        step();
        q0.push_back('{mode: 1'b1, steps: 3});
        push(1, 1'b0, 2);
        run_quiet(100);
        check("simul_out", 32'(cnt), 32'd1);

        // Fairness: both keep re-requesting 1-step jobs.
        pulse_reset();
        d0 = dut_dones;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{mode: 1'b1, steps: 1});
            q1.push_back('{mode: 1'b0, steps: 1});
        end
        drive_req();
        capture();
        run_quiet(200);
        check("fair_done_count", 32'(dut_dones - d0), 32'd8);

        // Zero-step job from requester 1.
        push(1, 1'b1, 0);
        run_quiet(50);

        // Reset in the middle of a 15-step run, after 4 enables.
        load_cnt(0);
        step();
        push(0, 1'b1, 15);
        while (cyc < m_en0 + 4) step();
        d0 = dut_dones;
        pulse_reset();
        step();
        check("no_done_after_rst", 32'(dut_dones - d0), 32'd0);
        check("rst_partial_out", 32'(cnt), 32'd4);
        push(0, 1'b0, 2);
        run_quiet(50);

        // Max count wrap from 3.
        load_cnt(3);
        step();
        push(0, 1'b1, 15);
        run_quiet(100);
        check("wrap_out", 32'(cnt), 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            int gap;
            int who;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            who = $urandom_range(0, 2);
            if (who != 1) q0.push_back('{mode: 1'($urandom_range(0, 1)), steps: $urandom_range(0, 15)});
            if (who != 0) q1.push_back('{mode: 1'($urandom_range(0, 1)), steps: $urandom_range(0, 15)});
            drive_req();
            if (cyc >= m_idle) capture();
        end
        run_quiet(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
